// File: rtl/vga_display_ctrl.sv
// vga_display_ctrl: frame-synchronous display mode FSM, win timer and pixel layer arbiter.
// Build option: define VGA_BORDER_EN for a white 8-pixel border in PLAY.
module vga_display_ctrl #(
  parameter int          H_VIS        = 640,
  parameter int          V_VIS        = 480,
  parameter int          WIN_FRAMES   = 300,
  parameter int          FLASH_FRAMES = 30,
  parameter logic [11:0] SPLASH_COL   = 12'h00F,
  parameter logic [11:0] LOSE_COL     = 12'hF00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MSM_State,
  input  logic        VS,
  input  logic [9:0]  ADDRH,
  input  logic [9:0]  ADDRY,
  input  logic        SNAKE_REQ,
  input  logic [11:0] SNAKE_COL,
  input  logic        TARGET_REQ,
  input  logic [11:0] TARGET_COL,
  input  logic [11:0] BG_COL,
  output logic [11:0] COLOUR_OUT,
  output logic [3:0]  VGA_FIN_OUT,
  output logic        FRAME_TICK
);

  localparam int WCW = $clog2(WIN_FRAMES);
  localparam int SCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN_FRAMES - 1);
  localparam logic [SCW-1:0] SUB_LAST = SCW'(FLASH_FRAMES - 1);
  localparam logic [9:0] H_LIM = 10'(H_VIS);
  localparam logic [9:0] V_LIM = 10'(V_VIS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_LOSE,
    S_WIN,
    S_DONE
  } state_t;

  state_t         state, state_n;
  logic [WCW-1:0] win_cnt, win_cnt_n;
  logic [SCW-1:0] sub_cnt, sub_cnt_n;
  logic [1:0]     flash_idx, flash_idx_n;
  logic           vs_q;
  logic [11:0]    colour_n;
  logic           blank;

  function automatic state_t decode(input logic [1:0] code);
    state_t s;
    unique case (code)
      2'b00: s = S_IDLE;
      2'b01: s = S_PLAY;
      2'b10: s = S_LOSE;
      2'b11: s = S_WIN;
    endcase
    return s;
  endfunction

  function automatic logic [11:0] palette(input logic [1:0] i);
    logic [11:0] c;
    unique case (i)
      2'd0: c = 12'hF00;
      2'd1: c = 12'h0F0;
      2'd2: c = 12'h00F;
      2'd3: c = 12'hFF0;
    endcase
    return c;
  endfunction

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= S_IDLE;
      win_cnt     <= '0;
      sub_cnt     <= '0;
      flash_idx   <= '0;
      vs_q        <= 1'b1;
      FRAME_TICK  <= 1'b0;
      COLOUR_OUT  <= '0;
      VGA_FIN_OUT <= '0;
    end else begin
      state       <= state_n;
      win_cnt     <= win_cnt_n;
      sub_cnt     <= sub_cnt_n;
      flash_idx   <= flash_idx_n;
      vs_q        <= VS;
      FRAME_TICK  <= vs_q & ~VS;
      COLOUR_OUT  <= colour_n;
      VGA_FIN_OUT <= (state_n == S_DONE) ? 4'h3 : 4'h0;
    end
  end

  // Mode only moves on a frame tick; DONE freezes every counter.
  always_comb begin
    state_n     = state;
    win_cnt_n   = win_cnt;
    sub_cnt_n   = sub_cnt;
    flash_idx_n = flash_idx;
    if (FRAME_TICK) begin
      unique case (state)
        S_WIN: begin
          if (MSM_State == 2'b11) begin
            if (sub_cnt == SUB_LAST) begin
              sub_cnt_n   = '0;
              flash_idx_n = flash_idx + 2'd1;
            end else begin
              sub_cnt_n = sub_cnt + 1'b1;
            end
            if (win_cnt == WIN_LAST) begin
              state_n = S_DONE;
            end else begin
              win_cnt_n = win_cnt + 1'b1;
            end
          end else begin
            state_n = decode(MSM_State);
          end
        end
        S_DONE: begin
          if (MSM_State != 2'b11) begin
            state_n = decode(MSM_State);
          end
        end
        default: begin
          state_n = decode(MSM_State);
          if (MSM_State == 2'b11) begin
            win_cnt_n   = '0;
            sub_cnt_n   = '0;
            flash_idx_n = '0;
          end
        end
      endcase
    end
  end

`ifdef VGA_BORDER_EN
  logic edge_px;
  assign edge_px = (ADDRH < 10'd8) || (ADDRH >= H_LIM - 10'd8) ||
                   (ADDRY < 10'd8) || (ADDRY >= V_LIM - 10'd8);
`endif

  assign blank = (ADDRH >= H_LIM) || (ADDRY >= V_LIM);

  always_comb begin
    colour_n = 12'h000;
    if (!blank) begin
      unique case (state)
        S_IDLE: colour_n = SPLASH_COL;
        S_LOSE: colour_n = LOSE_COL;
        S_PLAY: begin
`ifdef VGA_BORDER_EN
          if (edge_px)         colour_n = 12'hFFF;
          else if (SNAKE_REQ)  colour_n = SNAKE_COL;
          else if (TARGET_REQ) colour_n = TARGET_COL;
          else                 colour_n = BG_COL;
`else
          if (SNAKE_REQ)       colour_n = SNAKE_COL;
          else if (TARGET_REQ) colour_n = TARGET_COL;
          else                 colour_n = BG_COL;
`endif
        end
        S_WIN, S_DONE: colour_n = palette(flash_idx);
      endcase
    end
  end

endmodule
